ksort_drain: RTL and testbench

- Read-side companion of the k_sort engine inside Misc.
- On a start pulse it snapshots the K parallel sorted values and indices from k_sort, then streams them out one entry per cycle over a valid/ready interface, rank 0 first.
- After the last entry is accepted it pulses clear_reg back to k_sort, so the sorter is emptied for the next query batch (e.g. next kNN test sample).

---
 rtl/ksort_drain.sv | 176 +++++++++++++++++
 tb/tb_ksort_drain.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ksort_drain.sv
// ksort_drain: read-side companion of the k_sort engine.
// When start is pulsed, this block takes a snapshot of the K sorted values
// and indices from k_sort. It then streams them out one entry per cycle on a
// valid/ready interface, starting at rank 0. After the final entry is
// accepted it pulses clear_reg so the sorter is emptied for the next batch.
// Every output is driven straight from a register.
module ksort_drain #(
  parameter int WIDTH = 32,
  parameter int K     = 20,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num,
  input  logic [WIDTH-1:0] ksort_val [K-1:0],
  input  logic [WIDTH-1:0] ksort_idx [K-1:0],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_index,
  output logic [CNT_W-1:0] out_rank,
  output logic             out_last,
  output logic             busy,
  output logic             clear_reg,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t           state_q, state_d;

  logic [WIDTH-1:0] valSnap_q [K-1:0];
  logic [WIDTH-1:0] idxSnap_q [K-1:0];

  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] rank_q, rank_d;
  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] outData_q, outData_d;
  logic [WIDTH-1:0] outIndex_q, outIndex_d;
  logic             outLast_q, outLast_d;
  logic             busy_q, busy_d;
  logic             clear_q, clear_d;
  logic             done_q, done_d;

  logic             capture;
  logic             handshake;
  logic [CNT_W-1:0] numClamped;
  logic [CNT_W-1:0] nextRank;

  // A start request is accepted only in IDLE. The requested count is limited to K.
  assign capture    = (state_q == IDLE) && start;
  assign handshake  = outValid_q && out_ready;
  assign numClamped = (num > CNT_W'(K)) ? CNT_W'(K) : num;
  assign nextRank   = rank_q + CNT_W'(1);

  // The snapshot loads once per accepted start and is then held for the whole
  // drain. It has no reset because its contents are unused until loaded.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < K; i++) begin
        valSnap_q[i] <= ksort_val[i];
        idxSnap_q[i] <= ksort_idx[i];
      end
    end
  end

  // Next-state and next-output logic. Each output register holds its value
  // unless a state event below changes it.
  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    rank_d     = rank_q;
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outIndex_d = outIndex_q;
    outLast_d  = outLast_q;
    busy_d     = busy_q;
    clear_d    = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          num_d      = numClamped;
          rank_d     = '0;
          outData_d  = ksort_val[0];
          outIndex_d = ksort_idx[0];
          busy_d     = 1'b1;
          if (numClamped != '0) begin
            state_d    = SEND;
            outValid_d = 1'b1;
            outLast_d  = (numClamped == CNT_W'(1));
          end else begin
            state_d    = CLEAR;
            outValid_d = 1'b0;
            outLast_d  = 1'b0;
            clear_d    = 1'b1;
            done_d     = 1'b1;
          end
        end
      end

      SEND: begin
        if (handshake) begin
          if (outLast_q) begin
            state_d    = CLEAR;
            outValid_d = 1'b0;
            outLast_d  = 1'b0;
            clear_d    = 1'b1;
            done_d     = 1'b1;
          end else begin
            rank_d     = nextRank;
            outData_d  = valSnap_q[nextRank];
            outIndex_d = idxSnap_q[nextRank];
            outLast_d  = (nextRank == (num_q - CNT_W'(1)));
          end
        end
      end

      CLEAR: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d    = IDLE;
        outValid_d = 1'b0;
        outLast_d  = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and output registers. A synchronous reset aborts any drain and
  // returns to IDLE without a clear or done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      num_q      <= '0;
      rank_q     <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outIndex_q <= '0;
      outLast_q  <= 1'b0;
      busy_q     <= 1'b0;
      clear_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      rank_q     <= rank_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outIndex_q <= outIndex_d;
      outLast_q  <= outLast_d;
      busy_q     <= busy_d;
      clear_q    <= clear_d;
      done_q     <= done_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_index = outIndex_q;
  assign out_rank  = rank_q;
  assign out_last  = outLast_q;
  assign busy      = busy_q;
  assign clear_reg = clear_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ksort_drain.sv
// Directed testbench for ksort_drain with K=20, WIDTH=32 and CNT_W=5.
module tb_ksort_drain;

  localparam int WIDTH = 32;
  localparam int K     = 20;
  localparam int CNT_W = 5;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num;
  logic [WIDTH-1:0] ksortVal [K-1:0];
  logic [WIDTH-1:0] ksortIdx [K-1:0];
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] outData;
  logic [WIDTH-1:0] outIndex;
  logic [CNT_W-1:0] outRank;
  logic             outLast;
  logic             busy;
  logic             clearReg;
  logic             done;

  int checks = 0;
  int errors = 0;

  ksort_drain #(.WIDTH(WIDTH), .K(K), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num       (num),
    .ksort_val (ksortVal),
    .ksort_idx (ksortIdx),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (outData),
    .out_index (outIndex),
    .out_rank  (outRank),
    .out_last  (outLast),
    .busy      (busy),
    .clear_reg (clearReg),
    .done      (done)
  );

  // Free-running clock with a 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backstop that stops a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  // Advance one cycle. Inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadPattern();
    for (int i = 0; i < K; i++) begin
      ksortVal[i] = 32'(100 + i);
      ksortIdx[i] = 32'(i);
    end
  endtask

  // Issue a one-cycle start. On return the first post-start cycle is being sampled.
  task automatic pulseStart(input logic [CNT_W-1:0] n);
    num   = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num = '0; outReady = 1'b0;
    loadPattern();
    tick(); tick();
    checks++;
    if ({outValid, outLast, busy, clearReg, done} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b expected 00000", {outValid, outLast, busy, clearReg, done});
    end
    checks++;
    if ({outData, outIndex, outRank} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data got %h/%h/%0d expected 0", outData, outIndex, outRank);
    end
    // A start that coincides with reset must be ignored.
    start = 1'b1; num = 5'd3;
    tick();
    start = 1'b0; rst = 1'b0;
    tick();
    checks++;
    if ({outValid, busy, clearReg, done} !== 4'b0) begin
      errors++;
      $display("[TB] FAIL start_with_reset got %b expected 0000", {outValid, busy, clearReg, done});
    end
  endtask

  task automatic test_full_drain();
    loadPattern();
    outReady = 1'b1;
    pulseStart(5'd20);
    for (int r = 0; r < K; r++) begin
      checks++;
      if ({outValid, busy, clearReg, done} !== 4'b1100 || outRank !== 5'(r) ||
          outData !== 32'(100 + r) || outIndex !== 32'(r) || outLast !== (r == K - 1)) begin
        errors++;
        $display("[TB] FAIL full_entry%0d got v%b b%b c%b d%b rank %0d data %0d idx %0d last %b expected rank %0d data %0d last %b",
                 r, outValid, busy, clearReg, done, outRank, outData, outIndex, outLast, r, 100 + r, (r == K - 1));
      end
      tick();
    end
    checks++;
    if ({outValid, busy, clearReg, done} !== 4'b0111) begin
      errors++;
      $display("[TB] FAIL full_clear got v/b/c/d %b expected 0111", {outValid, busy, clearReg, done});
    end
    tick();
    checks++;
    if ({outValid, busy, clearReg, done} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL full_idle got v/b/c/d %b expected 0000", {outValid, busy, clearReg, done});
    end
  endtask

  task automatic test_backpressure();
    int  xfers;
    bit  doneSeen;
    loadPattern();
    outReady = 1'b0;
    pulseStart(5'd3);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outValid !== 1'b1 || outRank !== 5'd0 || outData !== 32'd100 || outLast !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d got v%b rank %0d data %0d last %b expected 1/0/100/0",
                 i, outValid, outRank, outData, outLast);
      end
      tick();
    end
    outReady = 1'b1;
    xfers = 0;
    doneSeen = 1'b0;
    for (int c = 0; c < 20 && !doneSeen; c++) begin
      if (done) doneSeen = 1'b1;
      if (outValid && outReady) begin
        checks++;
        if (outRank !== 5'(xfers) || outData !== 32'(100 + xfers) || outLast !== (xfers == 2)) begin
          errors++;
          $display("[TB] FAIL bp_xfer%0d got rank %0d data %0d last %b expected rank %0d data %0d last %b",
                   xfers, outRank, outData, outLast, xfers, 100 + xfers, (xfers == 2));
        end
        xfers++;
      end
      if (!doneSeen) tick();
    end
    checks++;
    if (!doneSeen || xfers != 3) begin
      errors++;
      $display("[TB] FAIL bp_count got xfers %0d done %b expected 3 and 1", xfers, doneSeen);
    end
    tick();
  endtask

  task automatic test_zero_num();
    int validCount;
    outReady = 1'b1;
    pulseStart(5'd0);
    checks++;
    if ({outValid, busy, clearReg, done} !== 4'b0111) begin
      errors++;
      $display("[TB] FAIL zero_clear got v/b/c/d %b expected 0111", {outValid, busy, clearReg, done});
    end
    validCount = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (outValid) validCount++;
    end
    checks++;
    if (validCount != 0 || busy !== 1'b0 || clearReg !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_after got valid cycles %0d busy %b clear %b expected 0/0/0", validCount, busy, clearReg);
    end
  endtask

  task automatic test_clamp();
    int  xfers;
    int  lastRank;
    bit  doneSeen;
    loadPattern();
    outReady = 1'b1;
    pulseStart(5'd31);
    xfers = 0; lastRank = -1; doneSeen = 1'b0;
    for (int c = 0; c < 60 && !doneSeen; c++) begin
      if (done) doneSeen = 1'b1;
      if (outValid && outReady) begin
        xfers++;
        if (outLast) lastRank = int'(outRank);
      end
      if (!doneSeen) tick();
    end
    checks++;
    if (!doneSeen || xfers != 20 || lastRank != 19) begin
      errors++;
      $display("[TB] FAIL clamp got xfers %0d last rank %0d done %b expected 20/19/1", xfers, lastRank, doneSeen);
    end
    tick();
  endtask

  task automatic test_snapshot_isolation();
    int doneCount;
    int r;
    int badData;
    loadPattern();
    outReady = 1'b1;
    pulseStart(5'd20);
    for (int i = 0; i < K; i++) ksortVal[i] = 32'hFFFF_FFFF;
    doneCount = 0; badData = 0; r = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) doneCount++;
      if (outValid) begin
        if (outData !== 32'(100 + r) || outRank !== 5'(r)) badData++;
        r++;
      end
      start = (c == 5);
      num   = 5'd20;
      tick();
    end
    start = 1'b0;
    checks++;
    if (badData != 0 || r != 20) begin
      errors++;
      $display("[TB] FAIL snapshot got bad entries %0d entries %0d expected 0 and 20", badData, r);
    end
    checks++;
    if (doneCount != 1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_start got done pulses %0d busy %b expected 1 and 0", doneCount, busy);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    loadPattern();
    outReady = 1'b1;
    pulseStart(5'd20);
    for (int r = 0; r < 6; r++) begin
      checks++;
      if (outRank !== 5'(r) || outData !== 32'(100 + r)) begin
        errors++;
        $display("[TB] FAIL rmid_pre%0d got rank %0d data %0d expected %0d/%0d", r, outRank, outData, r, 100 + r);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({outValid, outLast, busy, clearReg, done} !== 5'b0 || {outData, outIndex, outRank} !== '0) begin
      errors++;
      $display("[TB] FAIL rmid_zero got v%b l%b b%b c%b d%b data %0d idx %0d rank %0d expected all 0",
               outValid, outLast, busy, clearReg, done, outData, outIndex, outRank);
    end
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (clearReg || done || outValid) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL rmid_nopulse got active cycles %0d expected 0", pulses);
    end
    pulseStart(5'd2);
    checks++;
    if (outValid !== 1'b1 || outRank !== 5'd0 || outData !== 32'd100 || outIndex !== 32'd0) begin
      errors++;
      $display("[TB] FAIL rmid_restart got v%b rank %0d data %0d expected 1/0/100", outValid, outRank, outData);
    end
    tick();
    checks++;
    if (outRank !== 5'd1 || outData !== 32'd101 || outLast !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rmid_second got rank %0d data %0d last %b expected 1/101/1", outRank, outData, outLast);
    end
    tick();
    checks++;
    if ({outValid, clearReg, done} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL rmid_done got v/c/d %b expected 011", {outValid, clearReg, done});
    end
    tick();
  endtask

  // Run every scenario in sequence, then print the summary.
  initial begin
    test_reset();
    test_full_drain();
    test_backpressure();
    test_zero_num();
    test_clamp();
    test_snapshot_isolation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
